rv32i_memoryaccess: RTL and testbench
=====================================

# rv32i_memoryaccess

Memory-access stage of the rv32i core. It sits between execute and writeback, performs LOAD/STORE transactions on the data-memory port through a req/ack handshake, and handles byte-lane alignment, sign/zero extension and misalignment detection. It hands writeback a registered `data_load` word and a one-cycle `o_done` pulse per instruction, and it stalls the execute stage while a transaction is outstanding.

## Interface
- ACK_TIMEOUT, 255: the maximum number of cycles spent in REQ without `mem_ack` before the stage reports a bus error.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  execute presents an instruction this cycle.
- opcode  in  7  instruction class (LOAD 7'b000_0011, STORE 7'b010_0011; all others are pass-through).
- funct3  in  3  access width/sign.
- addr  in  32  effective byte address (ALU sum).
- rs2  in  32  store data.
- o_ready  out  1  the stage accepts an instruction this cycle; combinational, equal to (state == IDLE).
- o_done  out  1  one-cycle pulse: the instruction has completed; qualifies `data_load`, `o_misaligned` and `o_bus_err`.
- data_load  out  32  extended load result, registered.
- o_misaligned  out  1  the completed LOAD/STORE was misaligned; no bus access was made.
- o_bus_err  out  1  the completed access timed out.
- mem_req  out  1  request is active; held until ack or timeout.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word address, `{addr[31:2],2'b00}`.
- mem_wdata  out  32  store data replicated across lanes.
- mem_wstrb  out  4  byte-write enables; 0 for reads.
- mem_rdata  in  32  read data, valid when `mem_ack` = 1.
- mem_ack  in  1  the memory completes the request this cycle.

## Operation
- States are IDLE and REQ. Accept happens on `i_valid && o_ready`.
- **Accept of a non-LOAD/STORE instruction:** no request is issued. `o_done` = 1 next cycle. `data_load` keeps its value. The state stays IDLE.
- **Accept of a LOAD/STORE with a legal funct3:**
  - LOAD funct3 values: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - STORE funct3 values: 000 SB, 001 SH, 010 SW.
  - Alignment check: half requires `addr[0]`=0; word requires `addr[1:0]`=0.
  - If misaligned: no request is issued. Next cycle `o_done`=1 and `o_misaligned`=1; `data_load` keeps its value.
  - If aligned: the stage registers the mem_* outputs and moves to REQ.
- **Illegal funct3 on a LOAD/STORE:** no request is issued. Next cycle `o_done`=1 and `data_load`=0.
- **Store lanes:**
  - SB: `wdata = {4{rs2[7:0]}}`, `wstrb = 4'b0001 << addr[1:0]`.
  - SH: `wdata = {2{rs2[15:0]}}`, `wstrb = 4'b0011 << addr[1:0]`.
  - SW: `wdata = rs2`, `wstrb = 4'b1111`.
- **Load extract:** the selected byte is `mem_rdata[8*addr[1:0] +: 8]`; the selected half is `mem_rdata[16*addr[1] +: 16]`. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through. The registered `addr[1:0]` and funct3 are used.
- **REQ with `mem_ack`=1:**
  - Drop `mem_req`, `mem_we` and `mem_wstrb` next cycle and return to IDLE.
  - `o_done`=1 next cycle.
  - For a LOAD, `data_load` is updated with the extracted value; for a STORE, `data_load` is unchanged.
- **REQ timeout:** a counter clears on entry to REQ and increments each REQ cycle without ack. When it reaches ACK_TIMEOUT:
  - Drop `mem_req` and return to IDLE.
  - Next cycle `o_done`=1 and `o_bus_err`=1; `data_load`=0 for a LOAD.
  - An ack arriving in the same cycle as the timeout wins: the access completes normally.
- `mem_ack` while in IDLE is ignored. `i_valid` while in REQ is ignored; the upstream stage holds its instruction because `o_ready`=0.
- `o_misaligned` and `o_bus_err` are valid only with `o_done` and are 0 otherwise.

## Timing
- **Reset (async, `rst_n`=0):**
  - State = IDLE, so `o_ready`=1.
  - `o_done`, `o_misaligned`, `o_bus_err`, `mem_req`, `mem_we` = 0; `mem_wstrb`=0; `data_load`, `mem_addr`, `mem_wdata` = 0; timeout counter = 0.
  - Reset asserted mid-REQ aborts the transaction immediately with no `o_done`.
- **Memory op:** accepted at edge N → `mem_req`=1 during cycle N+1. With ack in cycle M (M ≥ N+1), `o_done` and `data_load` are valid in cycle M+1 and `o_ready`=1 in cycle M+1.
  - Minimum latency is 2 cycles (zero-wait memory acks in the first REQ cycle).
  - Back-to-back accept in cycle M+1 is allowed.
- **Pass-through, misaligned, illegal funct3:** 1 cycle; `o_ready` stays 1, so one instruction per cycle is sustained.
- `mem_addr`, `mem_wdata`, `mem_we` and `mem_wstrb` are stable for the whole time `mem_req`=1.
- Timeout: `mem_req` is high for exactly ACK_TIMEOUT cycles before it drops.

## Test plan
- **Reset check:** reset pulse mid-REQ → all outputs 0, `o_ready`=1, no `o_done`, and no `mem_req` in the following cycle.
- **LB with sign extension:** LB `addr`=0x1003, `mem_rdata`=0x80FF_1234, ack in the first REQ cycle → `mem_addr`=0x1000, `mem_wstrb`=0, `data_load`=0xFFFF_FF80, `o_done` 2 cycles after accept. The same access as LBU → `data_load`=0x0000_0080.
- **SH to the upper half:** SH `addr`=0x2002, `rs2`=0xDEAD_BEEF, ack after 3 wait cycles → `mem_wdata`=0xBEEF_BEEF, `mem_wstrb`=4'b1100, `mem_we`=1, request held stable 4 cycles, then `o_done`.
- **Misaligned accesses:** LW `addr`=0x3001 → no `mem_req`, next cycle `o_done`=1, `o_misaligned`=1, `data_load` unchanged. SH `addr`=0x3003 behaves the same way.
- **Timeout:** ACK_TIMEOUT=4, LW with no ack → `mem_req` high 4 cycles, then `o_done`=1, `o_bus_err`=1, `data_load`=0. Repeat with ack in the 4th cycle → normal completion, `o_bus_err`=0.
- **Mixed stream:** `i_valid` held high with R_TYPE, LW (zero-wait), SW, I_TYPE → one `o_done` per instruction, `o_ready` low only during the two REQ cycles, and stray `mem_ack` in IDLE is ignored.

Source files
------------

// File: rtl/rv32i_memoryaccess.sv
// rv32i memory-access stage: LOAD/STORE over a req/ack data port.
// Handles lane alignment, load extension, misalignment and ack timeout.
module rv32i_memoryaccess #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_valid,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] rs2,
    output logic        o_ready,
    output logic        o_done,
    output logic [31:0] data_load,
    output logic        o_misaligned,
    output logic        o_bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam logic [6:0] OP_LOAD  = 7'b000_0011;
    localparam logic [6:0] OP_STORE = 7'b010_0011;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_REQ  = 1'b1;

    localparam int unsigned CW_RAW = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned CW     = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          mis_q, mis_d;
    logic          berr_q, berr_d;
    logic [31:0]   data_q, data_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [31:0]   maddr_q, maddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic [2:0]    f3_q, f3_d;
    logic [1:0]    lo_q, lo_d;
    logic          ld_q, ld_d;

    logic        is_load;
    logic        is_store;
    logic        f3_legal;
    logic        misal;
    logic        accept;
    logic        c_pass;
    logic        c_ill;
    logic        c_mis;
    logic        c_go;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;

    assign o_ready      = (state_q == S_IDLE);
    assign o_done       = done_q;
    assign o_misaligned = mis_q;
    assign o_bus_err    = berr_q;
    assign data_load    = data_q;
    assign mem_req      = req_q;
    assign mem_we       = we_q;
    assign mem_addr     = maddr_q;
    assign mem_wdata    = wdata_q;
    assign mem_wstrb    = wstrb_q;

    assign is_load  = (opcode == OP_LOAD);
    assign is_store = (opcode == OP_STORE);
    assign accept   = i_valid && o_ready;

    always_comb begin
        f3_legal = 1'b0;
        if (is_load) begin
            unique case (funct3)
                3'b000, 3'b001, 3'b010,
                3'b100, 3'b101: f3_legal = 1'b1;
                default:        f3_legal = 1'b0;
            endcase
        end else if (is_store) begin
            f3_legal = (funct3[2] == 1'b0) && (funct3[1:0] != 2'b11);
        end
    end

    // Width lives in funct3[1:0] for both loads and stores.
    assign misal = ((funct3[1:0] == 2'b01) && addr[0])
                 || ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

    assign c_pass = accept && !(is_load || is_store);
    assign c_ill  = accept && (is_load || is_store) && !f3_legal;
    assign c_mis  = accept && f3_legal && misal;
    assign c_go   = accept && f3_legal && !misal;

    always_comb begin
        st_wdata = rs2;
        st_wstrb = 4'b1111;
        unique case (funct3[1:0])
            2'b00: begin
                st_wdata = {4{rs2[7:0]}};
                st_wstrb = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                st_wdata = {2{rs2[15:0]}};
                st_wstrb = 4'b0011 << addr[1:0];
            end
            default: begin
                st_wdata = rs2;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    assign ld_byte = mem_rdata[{lo_q, 3'b000} +: 8];
    assign ld_half = mem_rdata[{lo_q[1], 4'b0000} +: 16];

    always_comb begin
        unique case (f3_q)
            3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_val = {24'd0, ld_byte};
            3'b101:  ld_val = {16'd0, ld_half};
            default: ld_val = mem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        mis_d   = 1'b0;
        berr_d  = 1'b0;
        data_d  = data_q;
        req_d   = req_q;
        we_d    = we_q;
        maddr_d = maddr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        f3_d    = f3_q;
        lo_d    = lo_q;
        ld_d    = ld_q;

        unique case (state_q)
            S_IDLE: begin
                unique case (1'b1)
                    c_pass: done_d = 1'b1;
                    c_ill: begin
                        done_d = 1'b1;
                        data_d = 32'd0;
                    end
                    c_mis: begin
                        done_d = 1'b1;
                        mis_d  = 1'b1;
                    end
                    c_go: begin
                        state_d = S_REQ;
                        cnt_d   = '0;
                        req_d   = 1'b1;
                        we_d    = is_store;
                        maddr_d = {addr[31:2], 2'b00};
                        wstrb_d = is_store ? st_wstrb : 4'b0000;
                        if (is_store) wdata_d = st_wdata;
                        f3_d    = funct3;
                        lo_d    = addr[1:0];
                        ld_d    = is_load;
                    end
                    default: ;
                endcase
            end
            S_REQ: begin
                // A late ack takes priority over the timeout.
                if (mem_ack) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    wstrb_d = 4'b0000;
                    done_d  = 1'b1;
                    if (ld_q) data_d = ld_val;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    wstrb_d = 4'b0000;
                    done_d  = 1'b1;
                    berr_d  = 1'b1;
                    if (ld_q) data_d = 32'd0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
            berr_q  <= 1'b0;
            data_q  <= 32'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            maddr_q <= 32'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'b0000;
            f3_q    <= 3'b000;
            lo_q    <= 2'b00;
            ld_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            mis_q   <= mis_d;
            berr_q  <= berr_d;
            data_q  <= data_d;
            req_q   <= req_d;
            we_q    <= we_d;
            maddr_q <= maddr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            f3_q    <= f3_d;
            lo_q    <= lo_d;
            ld_q    <= ld_d;
        end
    end

endmodule

// File: tb/tb_rv32i_memoryaccess.sv
// Scoreboard bench for rv32i_memoryaccess with directed vectors.
// Expected requests and completions are queued by stimulus, checked by a monitor.
`timescale 1ns/1ps
module tb_rv32i_memoryaccess;

    localparam int TO = 4;
    localparam logic [6:0] LOAD  = 7'b000_0011;
    localparam logic [6:0] STORE = 7'b010_0011;
    localparam logic [6:0] RTYPE = 7'b011_0011;
    localparam logic [6:0] ITYPE = 7'b001_0011;

    typedef struct {
        logic [31:0] a;
        logic        we;
        logic [31:0] wd;
        logic [3:0]  ws;
        int          len;
    } req_t;

    typedef struct {
        logic [31:0] d;
        logic        m;
        logic        b;
    } done_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0;
    logic [31:0] rs2 = '0;
    logic        o_ready;
    logic        o_done;
    logic [31:0] data_load;
    logic        o_misaligned;
    logic        o_bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    int n_total = 0;
    int n_pass = 0;

    req_t  req_q[$];
    done_t done_q[$];

    rv32i_memoryaccess #(.ACK_TIMEOUT(TO)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_valid(i_valid),
        .opcode(opcode),
        .funct3(funct3),
        .addr(addr),
        .rs2(rs2),
        .o_ready(o_ready),
        .o_done(o_done),
        .data_load(data_load),
        .o_misaligned(o_misaligned),
        .o_bus_err(o_bus_err),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata),
        .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    endtask

    task automatic exp_req(input logic [31:0] a, input logic we,
                           input logic [31:0] wd, input logic [3:0] ws,
                           input int len);
        req_t r;
        r.a = a; r.we = we; r.wd = wd; r.ws = ws; r.len = len;
        req_q.push_back(r);
    endtask

    task automatic exp_done(input logic [31:0] d, input logic m, input logic b);
        done_t e;
        e.d = d; e.m = m; e.b = b;
        done_q.push_back(e);
    endtask

    // waits: >=0 ack after that many extra REQ cycles, -1 no bus op, -2 never ack
    task automatic do_op(input string nm, input logic [6:0] op,
                         input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input int waits,
                         input logic [31:0] rd);
        int g = 0;
        @(posedge clk); #1;
        while (!o_ready && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        chk({nm, "_ready"}, o_ready, 1);
        i_valid = 1'b1; opcode = op; funct3 = f3; addr = a; rs2 = d;
        @(posedge clk); #1;
        i_valid = 1'b0;
        if (waits >= 0) begin
            repeat (waits) begin @(posedge clk); #1; end
            mem_ack = 1'b1;
            mem_rdata = rd;
            @(posedge clk); #1;
            mem_ack = 1'b0;
        end
        if (waits != -2) begin
            chk({nm, "_done_t"}, o_done, 1);
            chk({nm, "_ready_t"}, o_ready, 1);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a request or done.
    initial begin
        req_t cur;
        done_t e;
        logic in_req;
        int rlen;
        logic [31:0] ca, cwd;
        logic cwe;
        logic [3:0] cws;
        in_req = 1'b0;
        rlen = 0;
        cur.len = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_req = 1'b0;
            end else begin
                if (mem_req && !in_req) begin
                    chk("req_expected", 32'(req_q.size() != 0), 1);
                    if (req_q.size() != 0) begin
                        cur = req_q.pop_front();
                        chk("req_addr", mem_addr, cur.a);
                        chk("req_we", mem_we, cur.we);
                        chk("req_wstrb", mem_wstrb, cur.ws);
                        if (cur.we) chk("req_wdata", mem_wdata, cur.wd);
                    end
                    in_req = 1'b1;
                    rlen = 1;
                    ca = mem_addr; cwe = mem_we; cwd = mem_wdata; cws = mem_wstrb;
                end else if (mem_req) begin
                    rlen++;
                    chk("req_stable", 32'({mem_addr, mem_we, mem_wdata, mem_wstrb}
                        == {ca, cwe, cwd, cws}), 1);
                end else if (in_req) begin
                    in_req = 1'b0;
                    if (cur.len != 0) chk("req_len", rlen, cur.len);
                end
                if (o_done) begin
                    chk("done_expected", 32'(done_q.size() != 0), 1);
                    if (done_q.size() != 0) begin
                        e = done_q.pop_front();
                        chk("done_data", data_load, e.d);
                        chk("done_mis", o_misaligned, e.m);
                        chk("done_berr", o_bus_err, e.b);
                    end
                end else begin
                    chk("flags_idle", {o_misaligned, o_bus_err}, 0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lowcnt;
        #12;
        chk("rst_ready", o_ready, 1);
        chk("rst_done", o_done, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_data", data_load, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wstrb", mem_wstrb, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        exp_req(32'h1000, 0, 0, 4'b0000, 1);
        exp_done(32'hFFFF_FF80, 0, 0);
        do_op("lb", LOAD, 3'b000, 32'h1003, 0, 0, 32'h80FF_1234);
        exp_req(32'h1000, 0, 0, 4'b0000, 1);
        exp_done(32'h0000_0080, 0, 0);
        do_op("lbu", LOAD, 3'b100, 32'h1003, 0, 0, 32'h80FF_1234);
        exp_req(32'h1000, 0, 0, 4'b0000, 1);
        exp_done(32'hFFFF_80FF, 0, 0);
        do_op("lh", LOAD, 3'b001, 32'h1002, 0, 0, 32'h80FF_1234);
        exp_req(32'h1000, 0, 0, 4'b0000, 1);
        exp_done(32'h0000_1234, 0, 0);
        do_op("lhu", LOAD, 3'b101, 32'h1000, 0, 0, 32'h80FF_1234);

        exp_req(32'h2000, 1, 32'hBEEF_BEEF, 4'b1100, 4);
        exp_done(32'h0000_1234, 0, 0);
        do_op("sh", STORE, 3'b001, 32'h2002, 32'hDEAD_BEEF, 3, 0);
        exp_req(32'h5000, 1, 32'hA5A5_A5A5, 4'b0010, 1);
        exp_done(32'h0000_1234, 0, 0);
        do_op("sb", STORE, 3'b000, 32'h5001, 32'h0000_00A5, 0, 0);
        exp_req(32'h6000, 1, 32'hCAFE_F00D, 4'b1111, 2);
        exp_done(32'h0000_1234, 0, 0);
        do_op("sw", STORE, 3'b010, 32'h6000, 32'hCAFE_F00D, 1, 0);

        exp_done(32'h0000_1234, 1, 0);
        do_op("lw_mis", LOAD, 3'b010, 32'h3001, 0, -1, 0);
        exp_done(32'h0000_1234, 1, 0);
        do_op("sh_mis", STORE, 3'b001, 32'h3003, 32'h1111_2222, -1, 0);
        exp_done(32'h0000_1234, 1, 0);
        do_op("lw_mis2", LOAD, 3'b010, 32'h3002, 0, -1, 0);

        exp_done(32'h0000_0000, 0, 0);
        do_op("ld_ill", LOAD, 3'b011, 32'h3000, 0, -1, 0);
        exp_req(32'h4008, 0, 0, 4'b0000, 1);
        exp_done(32'h1234_5678, 0, 0);
        do_op("lw", LOAD, 3'b010, 32'h4008, 0, 0, 32'h1234_5678);
        exp_done(32'h0000_0000, 0, 0);
        do_op("st_ill", STORE, 3'b100, 32'h3000, 0, -1, 0);

        exp_req(32'h4000, 0, 0, 4'b0000, TO);
        exp_done(32'h0000_0000, 0, 1);
        do_op("lw_to", LOAD, 3'b010, 32'h4000, 0, -2, 0);
        repeat (TO) begin @(posedge clk); #1; end
        chk("lw_to_done_t", o_done, 1);
        chk("lw_to_berr_t", o_bus_err, 1);
        exp_req(32'h4004, 0, 0, 4'b0000, TO);
        exp_done(32'h89AB_CDEF, 0, 0);
        do_op("lw_late", LOAD, 3'b010, 32'h4004, 0, TO - 1, 32'h89AB_CDEF);
        exp_req(32'h4010, 1, 32'h0000_0055, 4'b1111, TO);
        exp_done(32'h89AB_CDEF, 0, 1);
        do_op("sw_to", STORE, 3'b010, 32'h4010, 32'h0000_0055, -2, 0);
        repeat (TO) begin @(posedge clk); #1; end
        chk("sw_to_done_t", o_done, 1);
        exp_done(32'h89AB_CDEF, 0, 0);
        do_op("rtype", RTYPE, 3'b000, 32'h1234_5670, 0, -1, 0);

        // Mixed stream with i_valid held high.
        lowcnt = 0;
        @(posedge clk); #1;
        exp_done(32'h89AB_CDEF, 0, 0);
        i_valid = 1'b1; opcode = RTYPE; funct3 = 3'b000; addr = 32'h7000;
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        lowcnt += int'(!o_ready);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        opcode = LOAD; funct3 = 3'b010; addr = 32'h7000;
        exp_req(32'h7000, 0, 0, 4'b0000, 1);
        exp_done(32'h0BAD_F00D, 0, 0);
        lowcnt += int'(!o_ready);
        @(posedge clk); #1;
        opcode = STORE; funct3 = 3'b010; addr = 32'h7004; rs2 = 32'h1122_3344;
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
        exp_req(32'h7004, 1, 32'h1122_3344, 4'b1111, 1);
        exp_done(32'h0BAD_F00D, 0, 0);
        lowcnt += int'(!o_ready);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        lowcnt += int'(!o_ready);
        @(posedge clk); #1;
        opcode = ITYPE; funct3 = 3'b000; addr = 32'h0000_0010;
        mem_ack = 1'b1;
        exp_done(32'h0BAD_F00D, 0, 0);
        lowcnt += int'(!o_ready);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        lowcnt += int'(!o_ready);
        @(posedge clk); #1;
        i_valid = 1'b0;
        lowcnt += int'(!o_ready);
        chk("mix_ready_low", lowcnt, 2);
        repeat (3) begin @(posedge clk); #1; end

        // Reset asserted in the middle of a request.
        exp_req(32'h8000, 0, 0, 4'b0000, 0);
        do_op("rst_lw", LOAD, 3'b010, 32'h8000, 0, -2, 0);
        @(posedge clk); #1;
        chk("mid_req_before", mem_req, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", mem_req, 0);
        chk("mid_rst_ready", o_ready, 1);
        chk("mid_rst_done", o_done, 0);
        chk("mid_rst_data", data_load, 0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_wdata", mem_wdata, 0);
        chk("mid_rst_flags", {o_misaligned, o_bus_err, mem_we, mem_wstrb}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_req", mem_req, 0);
        chk("post_rst_done", o_done, 0);
        chk("post_rst_ready", o_ready, 1);

        repeat (5) begin @(posedge clk); #1; end
        chk("req_q_empty", req_q.size(), 0);
        chk("done_q_empty", done_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
